// File: rtl/dwave_pkg.sv
// Shared definitions for the d-waveform filter controller: FSM state
// encoding and default timing parameters.
package dwave_pkg;

   localparam int DEF_SYNC_STAGES   = 2;
   localparam int DEF_STABLE_CYCLES = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CHECK = 1'b1
   } state_e;

endpackage : dwave_pkg

// File: rtl/dwave_sync.sv
// Multi-flop synchronizer for the asynchronous d input. d_s is the last
// stage and is the only copy of d the rest of the design may look at.
module dwave_sync
   import dwave_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic d_s
);

   logic [SYNC_STAGES-1:0] sync_q;

   // Shift d through the chain on every edge, independent of enable.
   // NOTE: the chain is a handful of flops, so it is reset; a stale 1 here
   // after reset would look like a real edge to the qualifier.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      end
   end

   assign d_s = sync_q[SYNC_STAGES-1];

endmodule : dwave_sync

// File: rtl/dwave_filter_ctrl.sv
// Sampling controller for the single-bit d->q capture path.
// d is synchronized, every level change must be seen on STABLE_CYCLES
// consecutive samples before q follows, and q changes are reported as
// one-cycle rise/fall pulses.
// Optional build macro: DWAVE_GLITCH_COUNT_EN adds the glitch_cnt output,
// a saturating count of candidate changes rejected during qualification.
module dwave_filter_ctrl
   import dwave_pkg::*;
#(
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             d,
   output logic             q,
   output logic             rise,
   output logic             fall,
   output logic             busy
`ifdef DWAVE_GLITCH_COUNT_EN
   ,
   output logic [CNT_W-1:0] glitch_cnt
`endif
);

   localparam int STB_W = $clog2(STABLE_CYCLES) + 1;
   localparam logic [STB_W-1:0] CNT_LAST = STB_W'(STABLE_CYCLES - 1);

   // Reject illegal configurations at elaboration time.
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("dwave_filter_ctrl: SYNC_STAGES must be at least 2");
   end
   if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255) begin : g_bad_stable
      $error("dwave_filter_ctrl: STABLE_CYCLES must be in 2..255");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("dwave_filter_ctrl: CNT_W must be at least 1");
   end

   logic             d_s;
   state_e           state_q, state_d;
   logic [STB_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   dwave_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (d),
      .d_s   (d_s)
   );

   // Qualification FSM: next state, stable counter, level and event pulses.
   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (!en) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (d_s != level_q) begin
                  state_d = ST_CHECK;
                  cnt_d   = STB_W'(1);
               end
            end
            ST_CHECK: begin
               if (d_s == level_q) begin
                  state_d = ST_IDLE;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = ST_IDLE;
                  level_d = d_s;
                  rise_d  = d_s;
                  fall_d  = ~d_s;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         endcase
      end
   end

   // State, counter and output registers.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign q    = level_q;
   assign rise = rise_q;
   assign fall = fall_q;
   assign busy = (state_q == ST_CHECK);

`ifdef DWAVE_GLITCH_COUNT_EN
   logic             reject;
   logic [CNT_W-1:0] glitch_q, glitch_d;

   // A rejection is a CHECK that sees d_s fall back to q while enabled;
   // dropping en mid-check abandons the candidate without counting it.
   assign reject = en && (state_q == ST_CHECK) && (d_s == level_q);

   // Saturating increment of the rejection count.
   always_comb begin
      glitch_d = glitch_q;
      if (reject && (glitch_q != {CNT_W{1'b1}})) begin
         glitch_d = glitch_q + 1'b1;
      end
   end

   // Glitch counter register, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         glitch_q <= '0;
      end else begin
         glitch_q <= glitch_d;
      end
   end

   assign glitch_cnt = glitch_q;
`endif

endmodule : dwave_filter_ctrl

// File: doc/dwave_filter_ctrl.md
Name: dwave_filter_ctrl

Overview:
- Sampling controller for the single-bit d→q capture path.
- Synchronizes the asynchronous waveform input, qualifies each level change over a programmable number of consecutive clock samples, and only then updates the registered output.
- Emits one-cycle rise/fall event pulses for downstream logic.
- Removes sub-cycle glitches and short pulses of the kind the team's d-waveform stimulus exercises.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on d (legal range ≥2).
- STABLE_CYCLES, 3, consecutive differing samples required before q changes (legal range 2..255).
- CNT_W, 8, width of the glitch counter (used only under the optional feature).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  qualification enable; low freezes q.
- d  input  1  raw asynchronous waveform input.
- q  output  1  filtered, registered level.
- rise  output  1  one-cycle pulse when q goes 0→1.
- fall  output  1  one-cycle pulse when q goes 1→0.
- busy  output  1  high while a candidate change is being qualified.
- glitch_cnt  output  CNT_W  count of rejected changes (present only with the optional feature).

Behaviour:
- Reset, asynchronous on rst_n low and effective immediately, including mid-qualification:
  - sync chain = 0, q = 0, rise = fall = busy = 0.
  - state = IDLE, stable counter = 0, glitch_cnt = 0.
- Synchronizer: d shifts through SYNC_STAGES flops every edge regardless of en. d_s is the last stage.
- Stable counter width = clog2(STABLE_CYCLES) + 1.
- FSM, evaluated on every rising edge:
  - IDLE:
    - en=1 and d_s≠q → CHECK, cnt=1.
    - Otherwise stay in IDLE, cnt=0.
  - CHECK:
    - d_s==q → IDLE, cnt=0, change rejected (glitch event).
    - d_s≠q and cnt==STABLE_CYCLES-1 → q<=d_s, assert rise (if d_s=1) or fall (if d_s=0) for exactly that one cycle, go to IDLE, cnt=0.
    - Otherwise cnt<=cnt+1.
  - en=0 in any state → next state IDLE, cnt=0, q holds, no rise/fall. An abandoned qualification is not counted as a glitch.
- busy is combinational from the state register: busy = (state==CHECK).
- Latency: after d settles to a new level before edge e1, q changes at edge e1+SYNC_STAGES+STABLE_CYCLES-1. With defaults this is the 5th rising edge; rise/fall are high during the following cycle.
- Any pulse of d that is never sampled by the first sync flop (narrower than a clock period and between edges) has no effect and is not counted.
- rise and fall are never high together, and are never high on two consecutive cycles.
- The minimum q high or low time is STABLE_CYCLES clocks.

Optional Feature:
- Macro: DWAVE_GLITCH_COUNT_EN.
- Defined:
  - glitch_cnt port exists.
  - It increments by 1 on each CHECK→IDLE rejection and saturates at all-ones (no wrap).
  - It clears only on reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package dwave_pkg holds:
  - State encoding constants ST_IDLE=1'b0, ST_CHECK=1'b1.
  - Default values for SYNC_STAGES and STABLE_CYCLES.
- One sub-module, dwave_sync: parameterized SYNC_STAGES-deep flop chain with clk, rst_n, d in, d_s out, reset to 0.
- The FSM, counters and output registers stay in dwave_filter_ctrl.

Test Plan:
- Reset/idle:
  - Stimulus: assert rst_n=0 for 50ns with d=1, then release with en=1 and d=0.
  - Required response: q=0, rise=fall=busy=0, glitch_cnt=0; no activity for 10 cycles.
- Clean step:
  - Stimulus: clk period 40ns, en=1, d 0→1 5ns before edge k.
  - Required response: busy high after edge k+2; q=1 after edge k+4; rise=1 for exactly one cycle; fall stays 0.
- Narrow glitch:
  - Stimulus: 2ns high pulse on d placed between two rising edges.
  - Required response: q, busy, rise, glitch_cnt all unchanged.
- Short pulse:
  - Stimulus: d high for exactly 1 clock period, then 2 periods.
  - Required response: q stays 0 both times; busy high for 1 cycle and then 2 cycles; glitch_cnt=2 (with macro defined).
- Enable and reset interaction:
  - Stimulus: start a valid 0→1 step, then drop en during CHECK.
  - Required response: busy falls, q holds 0, glitch_cnt unchanged.
  - Stimulus: raise en with d still 1.
  - Required response: q=1 after STABLE_CYCLES further edges.
  - Stimulus: assert rst_n mid-CHECK.
  - Required response: all outputs 0 immediately, without waiting for a clock edge.
- Saturation:
  - Setup: CNT_W=2, macro defined.
  - Stimulus: 5 one-cycle pulses.
  - Required response: glitch_cnt stops at 3.
